// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the pipelined on-chip RAM slave.
// READ_LATENCY follows the optional ONCHIP_RAM_OUTREG_EN output register stage.
package onchip_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

`ifdef ONCHIP_RAM_OUTREG_EN
  localparam int READ_LATENCY = 2;
`else
  localparam int READ_LATENCY = 1;
`endif

  localparam int BYTE_WIDTH = 8;

endpackage

// File: rtl/onchip_ram_core.sv
// Inferred single-port RAM with byte-lane writes and a registered read port.
// Read data only changes on an enabled read, so it holds between reads.
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clken,
  input  logic                             we,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]            writedata,
  output logic [DATA_WIDTH-1:0]            readdata
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (clken && we) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (byteenable[i]) begin
          mem[address][i*BYTE_WIDTH +: BYTE_WIDTH] <= writedata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (clken && re) begin
      rdata_reg <= mem[address];
    end
  end

  assign readdata = rdata_reg;

endmodule

// File: rtl/onchip_ram_pipelined.sv
// Avalon-MM single-port RAM slave with optional post-reset zero-fill and stall support.
// Define ONCHIP_RAM_OUTREG_EN to add an output register stage (read latency 2).
module onchip_ram_pipelined
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             chipselect,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic                             read,
  input  logic                             write,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]            writedata,
  input  logic                             clken,
  input  logic                             reset_req,
  output logic                             waitrequest,
  output logic [DATA_WIDTH-1:0]            readdata,
  output logic                             readdatavalid,
  output logic                             init_done
);

  localparam int     NUM_BYTES   = DATA_WIDTH / BYTE_WIDTH;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   clear_cnt_reg;
  logic                    init_done_reg;
  logic [READ_LATENCY-1:0] vld_reg;

  logic                  run, clearing, clear_last;
  logic                  acc, acc_wr, acc_rd;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [NUM_BYTES-1:0]  ram_be;
  logic [DATA_WIDTH-1:0] ram_wdata, ram_rdata;

  // A stall freezes everything: clear sequencer, read pipeline and bus acceptance.
  assign run         = clken & ~reset_req;
  assign waitrequest = ~init_done_reg | ~run;
  assign acc         = chipselect & ~waitrequest;
  assign acc_wr      = acc & write;
  assign acc_rd      = acc & read & ~write;
  assign init_done   = init_done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RESET_STATE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_CLEAR && clear_last) begin
      state_next = ST_READY;
    end
  end

  always_comb begin
    clearing   = (state_reg == ST_CLEAR);
    clear_last = clearing & run & (&clear_cnt_reg);
    ram_we     = clearing ? run : acc_wr;
    ram_addr   = clearing ? clear_cnt_reg : address;
    ram_be     = clearing ? '1 : byteenable;
    ram_wdata  = clearing ? '0 : writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_cnt_reg <= '0;
      init_done_reg <= 1'b0;
    end else begin
      if (clearing && run) begin
        clear_cnt_reg <= clear_cnt_reg + ADDR_WIDTH'(1);
      end
      init_done_reg <= (state_next == ST_READY);
    end
  end

  // Valid bits advance only on enabled cycles; the output is gated so a stalled
  // pulse is emitted exactly once, on the first enabled cycle it reaches the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_reg <= '0;
    end else if (run) begin
      vld_reg[0] <= acc_rd;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_reg[i] <= vld_reg[i-1];
      end
    end
  end

  assign readdatavalid = vld_reg[READ_LATENCY-1] & run;

  onchip_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .clk        (clk),
    .rst        (reset),
    .clken      (run),
    .we         (ram_we),
    .re         (acc_rd),
    .address    (ram_addr),
    .byteenable (ram_be),
    .writedata  (ram_wdata),
    .readdata   (ram_rdata)
  );

`ifdef ONCHIP_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] dout_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_reg <= '0;
    end else if (run && vld_reg[0]) begin
      dout_reg <= ram_rdata;
    end
  end

  assign readdata = dout_reg;
`else
  assign readdata = ram_rdata;
`endif

endmodule

// File: doc/onchip_ram_pipelined.md
# onchip_ram_pipelined

Parametrised Avalon-MM single-port on-chip RAM slave for the Nios II system; successor to the fixed 1024×32 on-chip memory. It adds configurable width and depth, explicit read/readdatavalid pipelining, clken/reset_req stall via waitrequest, and an optional post-reset zero-fill sequencer that holds off the bus until the array is cleared. It sits on the system interconnect as a data/scratch memory.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 10, word address width; DEPTH = 2**ADDR_WIDTH words.
- CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset, 0 = skip it and leave contents undefined.

Ports (clk and reset: one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- chipselect  in  1  slave select.
- address  in  ADDR_WIDTH  word address.
- read  in  1  read request.
- write  in  1  write request.
- byteenable  in  DATA_WIDTH/8  per-byte write enable.
- writedata  in  DATA_WIDTH  write data.
- clken  in  1  clock enable; low = stall.
- reset_req  in  1  reset pending; high = stall, same as clken low.
- waitrequest  out  1  request not accepted this cycle.
- readdata  out  DATA_WIDTH  read data, qualified by readdatavalid.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- init_done  out  1  high once the array is usable.

## Operation
- Reset values: waitrequest=1, readdatavalid=0, readdata=0, init_done=0, clear counter=0.
- FSM states: ST_CLEAR, ST_READY.
  - Reset enters ST_CLEAR if CLEAR_ON_RESET=1, otherwise ST_READY.
  - ST_CLEAR writes 0 with all bytes enabled to counter address, one word per enabled cycle, then increments the counter. When the counter reaches DEPTH-1 and that write completes, the FSM goes to ST_READY and init_done rises.
  - ST_READY is held until reset.
- waitrequest = (state==ST_CLEAR) | ~clken | reset_req.
- A request is accepted when chipselect & ~waitrequest.
- Accepted write: only bytes with byteenable=1 are updated. byteenable=0 gives a no-op write that is still accepted.
- Accepted read: one readdatavalid pulse per read, issued in order. Back-to-back reads are accepted every cycle.
- read & write both high: write performed, read dropped, no readdatavalid.
- Read of an address written in the previous accepted cycle returns the new data.
- A stall (clken low or reset_req high) freezes the read pipeline and the clear counter. Pending readdatavalid pulses are delayed by the stall length, never lost or duplicated.
- Reset asserted mid-clear or mid-read: pipeline is flushed and the clear restarts at address 0.

## Timing
- Read latency is 1 cycle: readdatavalid and readdata appear in the cycle after acceptance.
- Write takes effect at the accepting edge.
- Clear duration is exactly DEPTH enabled cycles after reset deassertion. init_done and waitrequest=0 appear in cycle DEPTH+1 when not stalled.
- readdata holds its last value when readdatavalid=0.

## Configuration
- ONCHIP_RAM_OUTREG_EN defined: adds an output register stage. Read latency becomes 2 cycles, and the pipeline is 2 entries deep. Throughput is still one read per cycle.
- ONCHIP_RAM_OUTREG_EN undefined: latency is 1 cycle and there is no extra register.

## Structure
- Package onchip_ram_pkg holds:
  - state enum type (ST_CLEAR, ST_READY);
  - localparam READ_LATENCY (1, or 2 under ONCHIP_RAM_OUTREG_EN);
  - byte-lane width constant of 8.
- Sub-module onchip_ram_core: an inferred synchronous single-port RAM with byte enables, DATA_WIDTH × DEPTH, registered address, and write/clken inputs. The top level contains the FSM, the clear mux, waitrequest logic and the readdatavalid shift pipeline.

## Test plan
- Reset with CLEAR_ON_RESET=1 and ADDR_WIDTH=4 -> waitrequest high for exactly 16 cycles, then init_done=1. Reads of all 16 addresses return 0.
- Write 0xDEADBEEF to addr 5 with byteenable 0b0101, over prior value 0x11223344 -> read of addr 5 returns 0x11AD33EF with readdatavalid 1 cycle later (2 with the macro).
- Back-to-back reads of addr 0..7 on consecutive cycles -> 8 consecutive readdatavalid pulses, data in order.
- clken low for 3 cycles right after a read is accepted -> waitrequest high for those 3 cycles, and readdatavalid is delayed 3 cycles. Exactly one pulse occurs.
- reset asserted at clear count 7, released -> clear restarts at 0 and init_done rises DEPTH cycles after release.
- read and write high together at addr 3 with writedata 0xA5A5A5A5 -> no readdatavalid. A subsequent read of addr 3 returns 0xA5A5A5A5.
